wave_sel_ctrl: RTL and testbench

Parametrised successor to the DDS four-way waveform output mux. Selects one of NUM_CH phase-aligned waveform channels. Defers every selection change to the next phase wrap so the output never steps mid-cycle. Applies a per-output attenuation shift about midscale. Sits between the per-channel wave LUTs and the DAC/output pins.

---
 rtl/wave_sel_ctrl_if.sv | 25 ++
 rtl/wave_sel_ctrl.sv | 99 +++++++++
 tb/tb_wave_sel_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wave_sel_ctrl_if.sv
// Bundle between the channel LUTs / select keys and the output mux.
// The mux sits on the slave side; the source of samples and select drives master.
interface wave_sel_ctrl_if #(
   parameter int NUM_CH = 4,
   parameter int DW     = 8,
   parameter int SW     = 2
);
   logic [NUM_CH*DW-1:0] wave_in;
   logic [SW-1:0]        sel;
   logic                 phase_wrap;
   logic [1:0]           atten;
   logic [DW-1:0]        wave_out;
   logic [SW-1:0]        cur_sel;
   logic                 sel_busy;

   modport master (
      output wave_in, sel, phase_wrap, atten,
      input  wave_out, cur_sel, sel_busy
   );

   modport slave (
      input  wave_in, sel, phase_wrap, atten,
      output wave_out, cur_sel, sel_busy
   );
endinterface

// File: rtl/wave_sel_ctrl.sv
// Phase-aligned waveform channel selector with attenuation about midscale.
// Define WAVE_SEL_TIMEOUT_EN to force a pending switch after TIMEOUT wrap-less cycles.
module wave_sel_ctrl #(
   parameter int NUM_CH  = 4,
   parameter int DW      = 8,
   parameter int SW      = 2,
   parameter int TIMEOUT = 1023,
   parameter int TW      = 10
) (
   input logic            clk,
   input logic            rst_n,
   wave_sel_ctrl_if.slave bus
);
   localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
   localparam logic [SW:0]   NCH = (SW+1)'(NUM_CH);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                   state;
   logic [SW-1:0]            sel_q, sel_s, pend_sel, cur_sel;
   logic [DW-1:0]            wave_out;
   logic                     sel_ok, force_sw;
   logic [NUM_CH-1:0][DW-1:0] ch;
   logic [DW-1:0]            samp;
   logic signed [DW:0]       d, sh;

   assign sel_ok = {1'b0, sel_s} < NCH;

`ifdef WAVE_SEL_TIMEOUT_EN
   logic [TW-1:0] to_cnt;

   // Counter sits at zero outside WAIT, so entering WAIT always starts from 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            to_cnt <= '0;
      else if (state != S_WAIT || force_sw)  to_cnt <= '0;
      else                                   to_cnt <= to_cnt + 1'b1;
   end

   assign force_sw = bus.phase_wrap || (to_cnt == TW'(TIMEOUT));
`else
   assign force_sw = bus.phase_wrap;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q    <= '0;
         sel_s    <= '0;
         pend_sel <= '0;
         cur_sel  <= '0;
         state    <= S_IDLE;
      end else begin
         sel_q <= bus.sel;
         sel_s <= sel_q;
         case (state)
            S_IDLE: begin
               if (sel_ok && sel_s != cur_sel) begin
                  pend_sel <= sel_s;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A commit wins over a same-cycle request; that request is
               // re-evaluated from IDLE on the next edge.
               if (force_sw) begin
                  cur_sel <= pend_sel;
                  state   <= S_IDLE;
               end else if (sel_s == cur_sel) begin
                  state <= S_IDLE;
               end else if (sel_ok && sel_s != pend_sel) begin
                  pend_sel <= sel_s;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ch = bus.wave_in;

   always_comb begin
      samp = ch[0];
      for (int i = 1; i < NUM_CH; i++)
         if (cur_sel == SW'(i)) samp = ch[i];
   end

   // Offset-binary to signed, shift, back; the shifted magnitude never exceeds
   // the original so the truncation cannot wrap.
   assign d  = $signed({1'b0, samp}) - $signed({1'b0, MID});
   assign sh = d >>> bus.atten;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wave_out <= MID;
      else        wave_out <= MID + sh[DW-1:0];
   end

   assign bus.wave_out = wave_out;
   assign bus.cur_sel  = cur_sel;
   assign bus.sel_busy = (state == S_WAIT);
endmodule

// File: tb/tb_wave_sel_ctrl.sv
// Scoreboard bench for wave_sel_ctrl: a reference model pushes expected outputs
// each edge, a monitor pops and compares; directed scenarios plus random traffic.
module tb_wave_sel_ctrl;
   localparam int NUM_CH  = 3;
   localparam int DW      = 8;
   localparam int SW      = 2;
   localparam int TIMEOUT = 15;
   localparam int TW      = 10;
   localparam int MID     = 1 << (DW-1);
   localparam int MASK    = (1 << DW) - 1;
`ifdef WAVE_SEL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wave_sel_ctrl_if #(.NUM_CH(NUM_CH), .DW(DW), .SW(SW)) bus ();

   wave_sel_ctrl #(.NUM_CH(NUM_CH), .DW(DW), .SW(SW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct { int out; int cur; int busy; } exp_t;
   exp_t q[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: synchroniser as a two-deep history of sel, selection as
   // "busy/pending/current" bookkeeping, output as integer arithmetic.
   int m_s1 = 0, m_s = 0, m_cur = 0, m_pend = 0, m_busy = 0, m_wcnt = 0;

   always @(posedge clk) begin
      int old_s, d, samp;
      bit commit;
      exp_t e;
      if (!rst_n) begin
         m_s1 = 0; m_s = 0; m_cur = 0; m_pend = 0; m_busy = 0; m_wcnt = 0;
      end else begin
         samp  = int'(bus.wave_in[m_cur*DW +: DW]);
         d     = samp - MID;
         e.out = (MID + (d >>> bus.atten)) & MASK;
         old_s = m_s;
         m_s   = m_s1;
         m_s1  = int'(bus.sel);
         if (m_busy == 0) begin
            if (old_s != m_cur && old_s < NUM_CH) begin
               m_pend = old_s; m_busy = 1; m_wcnt = 0;
            end
         end else begin
            commit = bus.phase_wrap || (TO_EN && m_wcnt == TIMEOUT);
            if (commit) begin
               m_cur = m_pend; m_busy = 0;
            end else if (old_s == m_cur) begin
               m_busy = 0;
            end else begin
               if (old_s < NUM_CH) m_pend = old_s;
               m_wcnt++;
            end
         end
         e.cur  = m_cur;
         e.busy = m_busy;
         q.push_back(e);
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && q.size() > 0) begin
         e = q.pop_front();
         check("sb_wave_out", int'(bus.wave_out), e.out);
         check("sb_cur_sel",  int'(bus.cur_sel),  e.cur);
         check("sb_sel_busy", int'(bus.sel_busy), e.busy);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      bus.wave_in    = {8'd3, 8'd2, 8'd1};
      bus.sel        = '0;
      bus.phase_wrap = 1'b0;
      bus.atten      = 2'd0;
      rst_n          = 1'b0;
      tick(3);
      check("rst_wave_out", int'(bus.wave_out), 8'h80);
      check("rst_cur_sel",  int'(bus.cur_sel), 0);
      check("rst_sel_busy", int'(bus.sel_busy), 0);
      rst_n = 1'b1;
      tick(1);
      check("post_rst_out", int'(bus.wave_out), 1);

      // Deferred switch 0 -> 2
      bus.sel = 2'd2;
      tick(2);
      check("busy_edge2", int'(bus.sel_busy), 0);
      tick(1);
      check("busy_edge3", int'(bus.sel_busy), 1);
      tick(10);
      check("defer_out", int'(bus.wave_out), 1);
      check("defer_cur", int'(bus.cur_sel), 0);
      bus.phase_wrap = 1'b1;
      tick(1);
      bus.phase_wrap = 1'b0;
      check("wrap_cur", int'(bus.cur_sel), 2);
      tick(1);
      check("wrap_out", int'(bus.wave_out), 3);

      // Cancel: 2 -> 1 -> 2
      bus.sel = 2'd1;
      tick(3);
      check("cancel_busy", int'(bus.sel_busy), 1);
      bus.sel = 2'd2;
      tick(3);
      check("cancel_idle", int'(bus.sel_busy), 0);
      check("cancel_cur", int'(bus.cur_sel), 2);

      // Last request wins: 2 -> 0 -> 1, then wrap
      bus.sel = 2'd0;
      tick(4);
      bus.sel = 2'd1;
      tick(4);
      bus.phase_wrap = 1'b1;
      tick(1);
      bus.phase_wrap = 1'b0;
      check("last_wins_cur", int'(bus.cur_sel), 1);

      // Out-of-range select ignored
      bus.sel = 2'd3;
      tick(6);
      check("invalid_busy", int'(bus.sel_busy), 0);
      check("invalid_cur", int'(bus.cur_sel), 1);

      // Attenuation on channel 1
      bus.wave_in = {8'd3, 8'hFF, 8'd1};
      bus.atten   = 2'd2;
      tick(2);
      check("atten2_ff", int'(bus.wave_out), 8'h9F);
      bus.wave_in = {8'd3, 8'h00, 8'd1};
      bus.atten   = 2'd1;
      tick(2);
      check("atten1_00", int'(bus.wave_out), 8'h40);
      bus.atten = 2'd0;

      // No wrap for a long time
      bus.sel = 2'd0;
      tick(103);
      check("timeout_cur", int'(bus.cur_sel), TO_EN ? 0 : 1);
      bus.phase_wrap = 1'b1;
      tick(1);
      bus.phase_wrap = 1'b0;
      tick(1);
      check("after_wrap_cur", int'(bus.cur_sel), 0);

      // Reset in the middle of WAIT
      bus.sel = 2'd2;
      tick(4);
      check("pre_rst_busy", int'(bus.sel_busy), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_out", int'(bus.wave_out), 8'h80);
      check("midrst_busy", int'(bus.sel_busy), 0);
      check("midrst_cur", int'(bus.cur_sel), 0);
      tick(2);
      rst_n = 1'b1;
      bus.sel = 2'd0;
      tick(4);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         bus.wave_in    = 24'($urandom);
         bus.atten      = 2'($urandom_range(0, 3));
         bus.phase_wrap = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 5) == 0) bus.sel = 2'($urandom_range(0, 3));
         tick(1);
      end
      bus.phase_wrap = 1'b0;
      tick(3);
      check("sb_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
